// File: rtl/pos_loader.sv
// Board-position loader: buffers a 64-square nibble frame from the host, validates it,
// then shifts it into the square chain on commit and publishes side-to-move/castle rights.
//
// state | meaning
// IDLE  | waiting for the first nibble of a frame
// FILL  | accepting nibbles, counting squares and tracking illegal codes
// FULL  | complete, clean frame buffered; waiting for commit
// SHIFT | streaming the buffer into the chain, one square per cycle
module pos_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [3:0] s_data,
  input  logic       s_last,
  input  logic       i_wtp,
  input  logic [3:0] i_castle,
  input  logic       i_commit,
  output logic       o_pos_valid,
  output logic [3:0] o_pos_data,
  output logic       o_wtp,
  output logic [3:0] o_castle_rights,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_loaded,
  output logic       o_err
);

  typedef enum logic [1:0] {IDLE, FILL, FULL, SHIFT} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic       bad;
  logic       pend_wtp;
  logic [3:0] pend_castle;
  logic [3:0] buf_mem [64];

  logic hs;
  logic illegal;
  logic bad_now;

  assign s_ready = rst_n & ((state == IDLE) | (state == FILL));
  assign hs      = s_valid & s_ready;
  assign illegal = (s_data == 4'h7) | (s_data == 4'h8) | (s_data == 4'hF);
  assign bad_now = bad | illegal;
  assign o_full  = (state == FULL);

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (hs) buf_mem[cnt] <= s_data;
  end

  // During SHIFT, cnt holds the index of the next square to present; it wraps
  // to 0 after the last beat, which marks the completion cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 6'd0;
      bad             <= 1'b0;
      pend_wtp        <= 1'b0;
      pend_castle     <= 4'd0;
      o_pos_valid     <= 1'b0;
      o_pos_data      <= 4'd0;
      o_wtp           <= 1'b0;
      o_castle_rights <= 4'd0;
      o_busy          <= 1'b0;
      o_loaded        <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_loaded <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (hs) begin
            if (s_last && (cnt == 6'd63) && !bad_now) begin
              state       <= FULL;
              pend_wtp    <= i_wtp;
              pend_castle <= i_castle;
              cnt         <= 6'd0;
              bad         <= 1'b0;
            end else if (s_last || (cnt == 6'd63)) begin
              state <= IDLE;
              o_err <= 1'b1;
              cnt   <= 6'd0;
              bad   <= 1'b0;
            end else begin
              state <= FILL;
              cnt   <= cnt + 6'd1;
              bad   <= bad_now;
            end
          end
        end
        FULL: begin
          if (i_commit) begin
            state       <= SHIFT;
            o_pos_valid <= 1'b1;
            o_busy      <= 1'b1;
            o_pos_data  <= buf_mem[0];
            cnt         <= 6'd1;
          end
        end
        SHIFT: begin
          if (cnt == 6'd0) begin
            state           <= IDLE;
            o_pos_valid     <= 1'b0;
            o_busy          <= 1'b0;
            o_pos_data      <= 4'd0;
            o_loaded        <= 1'b1;
            o_wtp           <= pend_wtp;
            o_castle_rights <= pend_castle;
          end else begin
            o_pos_data <= buf_mem[cnt];
            cnt        <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_loader.sv
// Directed bench for pos_loader: frame fill, backpressure, rejection paths,
// commit gating and reset during a shift burst.
module tb_pos_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_data;
  logic       s_last;
  logic       i_wtp;
  logic [3:0] i_castle;
  logic       i_commit;
  logic       o_pos_valid;
  logic [3:0] o_pos_data;
  logic       o_wtp;
  logic [3:0] o_castle_rights;
  logic       o_full;
  logic       o_busy;
  logic       o_loaded;
  logic       o_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] fr [64];

  always #5 clk = ~clk;

  pos_loader dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .i_wtp(i_wtp), .i_castle(i_castle), .i_commit(i_commit),
    .o_pos_valid(o_pos_valid), .o_pos_data(o_pos_data),
    .o_wtp(o_wtp), .o_castle_rights(o_castle_rights),
    .o_full(o_full), .o_busy(o_busy), .o_loaded(o_loaded), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start();
    logic [3:0] back [8];
    logic [3:0] front [8];
    back  = '{4'h3, 4'h5, 4'h4, 4'h2, 4'h1, 4'h4, 4'h5, 4'h3};
    front = '{4'hB, 4'hD, 4'hC, 4'hA, 4'h9, 4'hC, 4'hD, 4'hB};
    for (int i = 0; i < 64; i++) fr[i] = 4'h0;
    for (int i = 0; i < 8; i++) begin
      fr[i]      = back[i];
      fr[8 + i]  = 4'h6;
      fr[48 + i] = 4'hE;
      fr[56 + i] = front[i];
    end
  endtask

  task automatic send_frame(input int last_idx, input bit toggle,
                            output int hs_cnt, output bit pv_seen);
    hs_cnt  = 0;
    pv_seen = 1'b0;
    for (int i = 0; i <= last_idx; i++) begin
      if (toggle) begin
        s_valid = 1'b0;
        if (o_pos_valid) pv_seen = 1'b1;
        tick();
      end
      s_valid = 1'b1;
      s_data  = fr[i];
      s_last  = (i == last_idx);
      if (s_ready) hs_cnt++;
      if (o_pos_valid) pv_seen = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 4'h0;
  endtask

  task automatic do_shift(input string tag, input logic exp_wtp, input logic [3:0] exp_c);
    int vbad;
    vbad = 0;
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("%s_beat%0d", tag, k), 32'(o_pos_data), 32'(fr[k]));
      if (o_pos_valid !== 1'b1 || o_busy !== 1'b1 || s_ready !== 1'b0 ||
          o_loaded !== 1'b0 || o_full !== 1'b0) vbad++;
      tick();
    end
    chk({tag, "_shift_ctl"}, 32'(vbad), 32'd0);
    chk({tag, "_loaded"}, 32'(o_loaded), 32'd1);
    chk({tag, "_wtp"}, 32'(o_wtp), 32'(exp_wtp));
    chk({tag, "_castle"}, 32'(o_castle_rights), 32'(exp_c));
    chk({tag, "_valid_off"}, 32'(o_pos_valid), 32'd0);
    chk({tag, "_data_off"}, 32'(o_pos_data), 32'd0);
    chk({tag, "_busy_off"}, 32'(o_busy), 32'd0);
    tick();
    chk({tag, "_loaded_1cyc"}, 32'(o_loaded), 32'd0);
    chk({tag, "_ready_idle"}, 32'(s_ready), 32'd1);
  endtask

  initial begin
    int  hs;
    bit  pv;
    int  seen;
    logic [3:0] legal [13];

    rst_n = 1'b0; s_valid = 1'b0; s_data = 4'h0; s_last = 1'b0;
    i_wtp = 1'b0; i_castle = 4'h0; i_commit = 1'b0;
    #12;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_valid", 32'(o_pos_valid), 32'd0);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_wtp", 32'(o_wtp), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_rel", 32'(s_ready), 32'd1);
    tick();

    // Start position.
    set_start();
    i_wtp = 1'b1; i_castle = 4'hF;
    send_frame(63, 1'b0, hs, pv);
    i_wtp = 1'b0; i_castle = 4'h0;
    chk("start_hs", 32'(hs), 32'd64);
    chk("start_full", 32'(o_full), 32'd1);
    chk("start_ready_full", 32'(s_ready), 32'd0);
    chk("start_wtp_pre", 32'(o_wtp), 32'd0);
    do_shift("start", 1'b1, 4'hF);

    // Backpressure with a mixed legal pattern.
    legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < 64; i++) fr[i] = legal[(i * 5) % 13];
    i_wtp = 1'b0; i_castle = 4'h5;
    send_frame(63, 1'b1, hs, pv);
    i_wtp = 1'b1; i_castle = 4'hC;
    chk("bp_hs", 32'(hs), 32'd64);
    chk("bp_full", 32'(o_full), 32'd1);
    do_shift("bp", 1'b0, 4'h5);

    // Short frame, then a good frame.
    set_start();
    send_frame(9, 1'b0, hs, pv);
    chk("short_err", 32'(o_err), 32'd1);
    chk("short_ready", 32'(s_ready), 32'd1);
    chk("short_full", 32'(o_full), 32'd0);
    tick();
    chk("short_err_1cyc", 32'(o_err), 32'd0);
    i_wtp = 1'b1; i_castle = 4'h3;
    send_frame(63, 1'b0, hs, pv);
    i_wtp = 1'b0; i_castle = 4'h0;
    chk("after_short_full", 32'(o_full), 32'd1);
    do_shift("after_short", 1'b1, 4'h3);

    // Illegal code at index 20.
    set_start();
    fr[20] = 4'h7;
    i_wtp = 1'b0; i_castle = 4'h0;
    send_frame(63, 1'b0, hs, pv);
    chk("illegal_err", 32'(o_err), 32'd1);
    chk("illegal_full", 32'(o_full), 32'd0);
    chk("illegal_ready", 32'(s_ready), 32'd1);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    chk("illegal_no_shift", 32'(o_pos_valid), 32'd0);
    chk("illegal_wtp_kept", 32'(o_wtp), 32'd1);
    chk("illegal_castle_kept", 32'(o_castle_rights), 32'd3);

    // Commit held through IDLE and FILL.
    i_commit = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_pos_valid !== 1'b0) seen++;
    end
    chk("commit_idle", 32'(seen), 32'd0);
    set_start();
    fr[30] = 4'hD;
    i_wtp = 1'b0; i_castle = 4'hA;
    send_frame(63, 1'b0, hs, pv);
    i_commit = 1'b0;
    chk("commit_fill", 32'(pv), 32'd0);
    tick();
    tick();
    chk("full_hold", 32'(o_full), 32'd1);
    chk("full_ready", 32'(s_ready), 32'd0);
    chk("full_no_valid", 32'(o_pos_valid), 32'd0);
    do_shift("gated", 1'b0, 4'hA);

    // Reset at SHIFT beat 30.
    set_start();
    i_wtp = 1'b1; i_castle = 4'hF;
    send_frame(63, 1'b0, hs, pv);
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("abort_beat30", 32'(o_pos_data), 32'(fr[30]));
    chk("abort_valid_pre", 32'(o_pos_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(o_pos_valid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_wtp", 32'(o_wtp), 32'd0);
    chk("abort_castle", 32'(o_castle_rights), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_ready", 32'(s_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (o_loaded !== 1'b0 || o_pos_valid !== 1'b0 || o_full !== 1'b0) seen++;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
